// File: rtl/rede_io_sched.sv
// rede_io_sched: I/O scheduler between sample streams and the rede core.
// Buffers one input word per port and captures processor writes per port.
module rede_io_sched #(
    parameter int NUBITS = 31,
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int FCNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUBITS*NUIOIN-1:0] s_data,
    input  logic [NUIOIN-1:0]        s_valid,
    output logic [NUIOIN-1:0]        s_ready,
    input  logic [NUIOIN-1:0]        req_in,
    output logic [NUBITS-1:0]        io_in,
    input  logic [NUBITS-1:0]        io_out,
    input  logic [NUIOOU-1:0]        out_en,
    output logic [NUBITS*NUIOOU-1:0] m_data,
    output logic [NUIOOU-1:0]        m_valid,
    input  logic [NUIOOU-1:0]        m_ready,
    output logic                     proc_rst,
    output logic                     frame_done,
    output logic [FCNTW-1:0]         frame_cnt,
    output logic [NUIOIN-1:0]        err_under,
    output logic [NUIOOU-1:0]        err_over
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [NUIOIN-1:0] in_full_q, in_full_d;
    logic [NUIOIN-1:0] err_under_q, err_under_d;
    logic [NUBITS-1:0] hold_q [NUIOIN];
    logic [NUBITS-1:0] hold_d [NUIOIN];

    logic [NUIOOU-1:0]        m_valid_q, m_valid_d;
    logic [NUIOOU-1:0]        wr_mask_q, wr_mask_d;
    logic [NUIOOU-1:0]        err_over_q, err_over_d;
    logic [NUBITS*NUIOOU-1:0] m_data_q, m_data_d;
    logic [FCNTW-1:0]         frame_cnt_q, frame_cnt_d;
    logic                     frame_done_q, frame_done_d;
    logic                     proc_rst_q, proc_rst_d;

    logic              run;
    logic              clr_err;
    logic              clr_mask;
    logic [NUIOIN-1:0] rd;
    logic [NUIOIN-1:0] accept;
    logic [NUIOOU-1:0] wr;
    logic [NUIOOU-1:0] mask_upd;

    assign run    = (state_q == RUN);
    assign rd     = run ? req_in : '0;
    assign wr     = run ? out_en : '0;
    assign accept = s_valid & ~in_full_q;

    assign s_ready    = ~in_full_q;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign proc_rst   = proc_rst_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_under  = err_under_q;
    assign err_over   = err_over_q;

    // Lowest requested port drives the processor read bus in the strobe cycle
    always_comb begin
        io_in = '0;
        for (int k = NUIOIN - 1; k >= 0; k--) begin
            if (rd[k]) io_in = hold_q[k];
        end
    end

    // Run-control FSM: hold the core in reset until a full frame is buffered
    always_comb begin
        state_d  = state_q;
        clr_err  = 1'b0;
        clr_mask = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = FILL;
                    clr_err  = 1'b1;
                    clr_mask = 1'b1;
                end
            end
            FILL: begin
                if (!en) state_d = IDLE;
                else if (&in_full_q) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d  = IDLE;
                    clr_mask = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        proc_rst_d = (state_d == RUN);
    end

    // Input buffers: an accept in the same cycle as an empty read wins
    always_comb begin
        in_full_d = (in_full_q & ~rd) | accept;
        if (clr_err) err_under_d = '0;
        else err_under_d = err_under_q | (rd & ~in_full_q);
        for (int k = 0; k < NUIOIN; k++) begin
            hold_d[k] = hold_q[k];
            if (accept[k]) hold_d[k] = s_data[k*NUBITS +: NUBITS];
        end
    end

    // Output registers, overflow detection and frame accounting
    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = (m_valid_q & ~m_ready) | wr;
        if (clr_err) err_over_d = '0;
        else err_over_d = err_over_q | (wr & m_valid_q & ~m_ready);
        for (int j = 0; j < NUIOOU; j++) begin
            if (wr[j]) m_data_d[j*NUBITS +: NUBITS] = io_out;
        end
        mask_upd     = wr_mask_q | wr;
        wr_mask_d    = mask_upd;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        if (&mask_upd) begin
            wr_mask_d    = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + FCNTW'(1);
        end else if (clr_mask) begin
            wr_mask_d = '0;
        end
    end

    // State registers; reset discards all buffered data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            in_full_q    <= '0;
            err_under_q  <= '0;
            m_valid_q    <= '0;
            wr_mask_q    <= '0;
            err_over_q   <= '0;
            m_data_q     <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            proc_rst_q   <= 1'b0;
            for (int k = 0; k < NUIOIN; k++) hold_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            in_full_q    <= in_full_d;
            err_under_q  <= err_under_d;
            m_valid_q    <= m_valid_d;
            wr_mask_q    <= wr_mask_d;
            err_over_q   <= err_over_d;
            m_data_q     <= m_data_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
            proc_rst_q   <= proc_rst_d;
            for (int k = 0; k < NUIOIN; k++) hold_q[k] <= hold_d[k];
        end
    end

endmodule

// File: tb/tb_rede_io_sched.sv
// tb_rede_io_sched: directed scenario tasks for rede_io_sched.
// Frame counter is narrowed to 4 bits so the wrap can be reached quickly.
module tb_rede_io_sched;

    localparam int NB = 31;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int FW = 4;

    logic           clk;
    logic           rst;
    logic           en;
    logic [NB*NI-1:0] s_data;
    logic [NI-1:0]  s_valid;
    logic [NI-1:0]  s_ready;
    logic [NI-1:0]  req_in;
    logic [NB-1:0]  io_in;
    logic [NB-1:0]  io_out;
    logic [NO-1:0]  out_en;
    logic [NB*NO-1:0] m_data;
    logic [NO-1:0]  m_valid;
    logic [NO-1:0]  m_ready;
    logic           proc_rst;
    logic           frame_done;
    logic [FW-1:0]  frame_cnt;
    logic [NI-1:0]  err_under;
    logic [NO-1:0]  err_over;

    int errors = 0;
    int checks = 0;

    rede_io_sched #(
        .NUBITS(NB),
        .NUIOIN(NI),
        .NUIOOU(NO),
        .FCNTW (FW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .req_in    (req_in),
        .io_in     (io_in),
        .io_out    (io_out),
        .out_en    (out_en),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .proc_rst  (proc_rst),
        .frame_done(frame_done),
        .frame_cnt (frame_cnt),
        .err_under (err_under),
        .err_over  (err_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input logic [NB-1:0] base);
        for (int j = 0; j < NO; j++) begin
            out_en = NO'(1 << j);
            io_out = base + NB'(j);
            tick();
        end
        out_en = '0;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b0; s_data = '0; s_valid = '0;
        req_in = '0; io_out = '0; out_en = '0; m_ready = '0;
        tick();
        tick();
        checks++;
        if (s_ready !== 4'b1111) begin
            errors++; $display("FAIL reset_s_ready got=%b exp=1111", s_ready);
        end
        checks++;
        if ({proc_rst, frame_done, m_valid, frame_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outs got=%b%b%b%h exp=0",
                     proc_rst, frame_done, m_valid, frame_cnt);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fill;
        en = 1'b1;
        tick();
        for (int k = 0; k < NI; k++) begin
            s_valid = NI'(1 << k);
            s_data  = '0;
            s_data[k*NB +: NB] = NB'(10 * (k + 1));
            tick();
        end
        s_valid = '0;
        checks++;
        if (s_ready !== 4'b0000) begin
            errors++; $display("FAIL fill_s_ready got=%b exp=0000", s_ready);
        end
        checks++;
        if (proc_rst !== 1'b0) begin
            errors++; $display("FAIL fill_proc_rst got=%b exp=0", proc_rst);
        end
        tick();
        checks++;
        if (proc_rst !== 1'b1) begin
            errors++; $display("FAIL run_proc_rst got=%b exp=1", proc_rst);
        end
    endtask

    task automatic test_read;
        req_in = 4'b0100;
        #1;
        checks++;
        if (io_in !== 31'd30) begin
            errors++; $display("FAIL read_io_in got=%0d exp=30", io_in);
        end
        tick();
        req_in = '0;
        checks++;
        if (s_ready !== 4'b0100 || err_under !== 4'b0000) begin
            errors++;
            $display("FAIL read_after got=%b/%b exp=0100/0000", s_ready, err_under);
        end
    endtask

    task automatic test_underflow;
        req_in = 4'b0001;
        tick();
        s_valid = 4'b0001;
        s_data  = '0;
        s_data[0 +: NB] = 31'd7;
        #1;
        checks++;
        if (io_in !== 31'd10) begin
            errors++; $display("FAIL under_stale got=%0d exp=10", io_in);
        end
        tick();
        req_in = '0; s_valid = '0;
        checks++;
        if (err_under !== 4'b0001 || s_ready !== 4'b0100) begin
            errors++;
            $display("FAIL under_flags got=%b/%b exp=0001/0100", err_under, s_ready);
        end
        req_in = 4'b0001;
        #1;
        checks++;
        if (io_in !== 31'd7) begin
            errors++; $display("FAIL under_reload got=%0d exp=7", io_in);
        end
        tick();
        req_in = '0;
    endtask

    task automatic test_frame;
        m_ready = '0;
        for (int j = 0; j < NO; j++) begin
            out_en = NO'(1 << j);
            io_out = NB'(j + 1);
            tick();
            if (j == 2) begin
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++; $display("FAIL frame_early got=%b exp=0", frame_done);
                end
            end
        end
        out_en = '0;
        checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 4'd1) begin
            errors++;
            $display("FAIL frame_done got=%b cnt=%0d exp=1 cnt=1", frame_done, frame_cnt);
        end
        checks++;
        if (m_valid !== 4'b1111 || m_data !== {31'd4, 31'd3, 31'd2, 31'd1}) begin
            errors++; $display("FAIL frame_data got=%b %h", m_valid, m_data);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL frame_pulse got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_overflow;
        out_en = 4'b0001;
        io_out = 31'd5;
        tick();
        io_out = 31'd9;
        tick();
        out_en = '0;
        checks++;
        if (m_data[0 +: NB] !== 31'd9 || err_over !== 4'b0001) begin
            errors++;
            $display("FAIL over_data got=%0d/%b exp=9/0001", m_data[0 +: NB], err_over);
        end
        checks++;
        if (frame_done !== 1'b0 || frame_cnt !== 4'd1) begin
            errors++;
            $display("FAIL over_noframe got=%b/%0d exp=0/1", frame_done, frame_cnt);
        end
        m_ready = 4'b1110;
        tick();
        checks++;
        if (m_valid !== 4'b0001) begin
            errors++; $display("FAIL over_drain got=%b exp=0001", m_valid);
        end
        for (int j = 1; j < NO; j++) begin
            out_en = NO'(1 << j);
            io_out = NB'(20 + j);
            tick();
            if (j == 2) begin
                checks++;
                if (m_valid !== 4'b0101 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL over_mid got=%b/%b exp=0101/0", m_valid, frame_done);
                end
            end
        end
        out_en = '0;
        checks++;
        if (frame_done !== 1'b1 || frame_cnt !== 4'd2 || err_over !== 4'b0001) begin
            errors++;
            $display("FAIL over_frame got=%b/%0d/%b exp=1/2/0001",
                     frame_done, frame_cnt, err_over);
        end
    endtask

    task automatic test_wrap;
        m_ready = 4'b1111;
        tick();
        for (int f = 0; f < 13; f++) write_frame(NB'(100 + 4 * f));
        checks++;
        if (frame_cnt !== 4'hF) begin
            errors++; $display("FAIL wrap_pre got=%h exp=f", frame_cnt);
        end
        write_frame(31'd500);
        checks++;
        if (frame_cnt !== 4'h0 || frame_done !== 1'b1 || err_over !== 4'b0001) begin
            errors++;
            $display("FAIL wrap got=%h/%b/%b exp=0/1/0001", frame_cnt, frame_done, err_over);
        end
    endtask

    task automatic test_idle_reset;
        en = 1'b0;
        tick();
        checks++;
        if (proc_rst !== 1'b0) begin
            errors++; $display("FAIL idle_proc_rst got=%b exp=0", proc_rst);
        end
        req_in = 4'b1000;
        #1;
        checks++;
        if (io_in !== 31'd0) begin
            errors++; $display("FAIL idle_io_in got=%0d exp=0", io_in);
        end
        tick();
        req_in = '0;
        checks++;
        if (s_ready !== 4'b0101) begin
            errors++; $display("FAIL idle_keep got=%b exp=0101", s_ready);
        end
        en = 1'b1;
        tick();
        checks++;
        if (err_under !== 4'b0000 || err_over !== 4'b0000) begin
            errors++;
            $display("FAIL refill_clr got=%b/%b exp=0000/0000", err_under, err_over);
        end
        s_valid = 4'b0101;
        s_data  = '0;
        s_data[0 +: NB]    = 31'd50;
        s_data[2*NB +: NB] = 31'd60;
        tick();
        s_valid = '0;
        tick();
        checks++;
        if (proc_rst !== 1'b1) begin
            errors++; $display("FAIL rerun_proc_rst got=%b exp=1", proc_rst);
        end
        m_ready = '0;
        out_en  = 4'b0001;
        io_out  = 31'd11;
        tick();
        out_en = '0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 4'b1111 || proc_rst !== 1'b0 || m_valid !== 4'b0000) begin
            errors++;
            $display("FAIL async_rst got=%b/%b/%b exp=1111/0/0000", s_ready, proc_rst, m_valid);
        end
        checks++;
        if (m_data !== '0 || frame_cnt !== 4'h0 || err_under !== 4'b0000) begin
            errors++;
            $display("FAIL async_rst_regs got=%h/%h/%b exp=0", m_data, frame_cnt, err_under);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read();
        test_underflow();
        test_frame();
        test_overflow();
        test_wrap();
        test_idle_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rede_io_sched.md
Name: rede_io_sched

Overview:
- I/O scheduler between external sample streams and the `rede` network processor.
- Buffers one word per input port and serves the processor's one-hot `req_in` reads combinationally on `io_in`.
- Captures `io_out` on the one-hot `out_en` writes into per-port output registers with valid/ready handshakes.
- Holds the processor in reset until a full input frame is buffered; counts completed output frames and flags under/overflow.

Parameters:
- NUBITS, 31, data word width (signed, passed through unchanged).
- NUIOIN, 4, number of input ports.
- NUIOOU, 4, number of output ports.
- FCNTW, 16, frame counter width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  run enable.
- s_data  input  NUBITS*NUIOIN  packed input words; port k at bits [k*NUBITS +: NUBITS].
- s_valid  input  NUIOIN  per-port input valid.
- s_ready  output  NUIOIN  per-port input ready.
- req_in  input  NUIOIN  one-hot read strobe from processor.
- io_in  output  NUBITS  word to processor.
- io_out  input  NUBITS  word from processor.
- out_en  input  NUIOOU  one-hot write strobe from processor.
- m_data  output  NUBITS*NUIOOU  packed output words, same packing as `s_data`.
- m_valid  output  NUIOOU  per-port output valid.
- m_ready  input  NUIOOU  per-port output ready.
- proc_rst  output  1  processor reset, active-low, registered.
- frame_done  output  1  one-cycle pulse per completed output frame.
- frame_cnt  output  FCNTW  completed frame count.
- err_under  output  NUIOIN  sticky input underflow flags.
- err_over  output  NUIOOU  sticky output overflow flags.

Behaviour:
- Reset (`rst`=0, async): FSM=IDLE; all holding regs, `in_full`, `m_valid`, `m_data`, `wr_mask`, `frame_cnt`, `frame_done`, `err_*` and `proc_rst` go to 0.
  - `s_ready` is all 1s during reset (it is defined as `~in_full`).
  - Reset asserted mid-operation discards all buffered data.
- FSM states and transitions:
  - IDLE: `proc_rst`=0. `en`=1 → FILL; this transition clears `err_under`, `err_over`, `wr_mask`.
  - FILL: `proc_rst`=0. When all `in_full`=1 → RUN. `en`=0 → IDLE.
  - RUN: `proc_rst`=1, registered, so high on the first cycle in RUN. `en`=0 → IDLE; buffered data is kept, `wr_mask` is cleared.
- `req_in`/`out_en` are ignored outside RUN.
- Input port k:
  - `s_ready[k]` = `~in_full[k]` in every state.
  - On `s_valid[k]`&`s_ready[k]`: hold[k] ← `s_data` slice, `in_full[k]` ← 1.
  - RUN, `req_in[k]`=1 and `in_full[k]`=1: `in_full[k]` ← 0.
  - RUN, `req_in[k]`=1 and `in_full[k]`=0: `err_under[k]` ← 1. `io_in` shows the stale hold[k]. If an accept happens in that same cycle, the accept wins: `in_full[k]` ← 1.
- `io_in` is combinational: hold[lowest set index of `req_in`]; 0 when `req_in`=0. Zero latency, because the processor samples in the strobe cycle.
- Output port j:
  - RUN, `out_en[j]`=1: `m_data` slice ← `io_out`, `m_valid[j]` ← 1, `wr_mask[j]` ← 1.
  - If `m_valid[j]`=1 and `m_ready[j]`=0 in that cycle: `err_over[j]` ← 1; the new word overwrites the old one.
  - `m_valid[j]`&`m_ready[j]` with no `out_en[j]`: `m_valid[j]` ← 0. With `out_en[j]` in the same cycle, the new word is loaded and `m_valid` stays 1.
- Frame accounting:
  - When the updated `wr_mask` would be all 1s: `wr_mask` ← 0, `frame_done` ← 1 for exactly the next cycle, `frame_cnt` ← `frame_cnt`+1.
  - `frame_cnt` wraps from 2^FCNTW−1 to 0.
  - A repeated `out_en` to an already-marked port inside a frame does not advance the frame.
- Arithmetic: data is never modified; the only arithmetic is the `frame_cnt` increment, modulo 2^FCNTW.

Test Plan:
1. Reset, then `en`=1, load words 10,20,30,40 on ports 0–3 → FSM reaches RUN after the 4th accept; `proc_rst`=1 the following cycle; `s_ready`=0000.
2. RUN, `req_in`=0100 → `io_in`=30 in the same cycle; next cycle `s_ready`=0100, `in_full[2]`=0, `err_under`=0000.
3. RUN, `req_in`=0001 on empty port 0 while `s_valid[0]`=1 with data 7 → `io_in`=old hold[0]; `err_under[0]`=1; next cycle `in_full[0]`=1, hold[0]=7.
4. `m_ready`=0, `out_en` one-hot 0001,0010,0100,1000 with `io_out`=1,2,3,4 → `m_data`=4,3,2,1 (ports 3..0), `m_valid`=1111; `frame_done` pulses one cycle after the 4th write; `frame_cnt`=1.
5. `out_en`=0001 twice with `m_ready[0]`=0 (values 5 then 9) → `m_data` port0=9, `err_over[0]`=1, `wr_mask`=0001, no `frame_done`.
6. Preload `frame_cnt`=0xFFFF, complete a frame → `frame_cnt`=0x0000. Separately, drop `rst` mid-RUN → all outputs 0 immediately (async), `s_ready`=1111.
